// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing constants and transmitter state encoding
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL = 1'b1;
  localparam logic UART_IDLE_LVL = 1'b1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: byte FIFO with head data visible combinationally
// ports: clk/rst (async active-high flush), push/din write, pop/dout read head,
//        count occupancy, full/empty flags
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] rptr_q, wptr_q;
  logic [AW:0] count_q;
  logic wr, rd;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem_q[rptr_q];
  assign count = count_q;
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= din;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      count_q <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (rd) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter with internal baud divider
// ports: clk_100mhz/rst (async active-high), txbyte/txvalid/txready push handshake,
//        ftdi_tx serial line (idle high), busy, fifo_count queued bytes
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600,
  parameter int DEPTH  = 16
) (
  input  logic                   clk_100mhz,
  input  logic                   rst,
  input  logic [7:0]             txbyte,
  input  logic                   txvalid,
  output logic                   txready,
  output logic                   ftdi_tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  uart_tx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d;
  logic pop, full, empty, last;
  logic [7:0] head;
  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk_100mhz),
    .rst(rst),
    .push(txvalid && txready),
    .pop(pop),
    .din(txbyte),
    .dout(head),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  assign txready = !full;
  assign last = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign busy = (state_q != IDLE) || (fifo_count != '0);
  assign ftdi_tx = tx_q;
  always_comb begin
    state_d = state_q;
    cnt_d = last ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        pop = !empty;
        shift_d = empty ? shift_q : head;
        state_d = empty ? IDLE : START;
      end
      START: begin
        idx_d = last ? '0 : idx_q;
        state_d = last ? DATA : START;
      end
      DATA: begin
        shift_d = last ? shift_q >> 1 : shift_q;
        idx_d = last ? idx_q + 1'b1 : idx_q;
        state_d = (last && idx_q == 3'(UART_DATA_BITS - 1)) ? STOP : DATA;
      end
      STOP: begin
        // chain straight into the next start bit when more data is queued
        pop = last && !empty;
        shift_d = (last && !empty) ? head : shift_q;
        state_d = !last ? STOP : empty ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
    // the pin is registered from the next state so the start bit appears on the pop edge
    tx_d = state_d == START ? UART_START_LVL :
           state_d == DATA  ? shift_d[0] :
           state_d == STOP  ? UART_STOP_LVL : UART_IDLE_LVL;
  end
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      tx_q <= UART_IDLE_LVL;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;
  localparam int CPB = 16;
  logic clk_100mhz = 1'b0;
  logic rst = 1'b1;
  logic [7:0] txbyte_a = '0, txbyte_b = '0;
  logic txvalid_a = 1'b0, txvalid_b = 1'b0;
  logic txready_a, txready_b, ftdi_tx_a, ftdi_tx_b, busy_a, busy_b;
  logic [4:0] fifo_count_a;
  logic [2:0] fifo_count_b;
  int checks = 0;
  int failures = 0;
  always #5 clk_100mhz = ~clk_100mhz;
  uart_tx_buffered #(.CLK_HZ(16), .BAUD(1), .DEPTH(16)) dut_a (
    .clk_100mhz(clk_100mhz), .rst(rst), .txbyte(txbyte_a), .txvalid(txvalid_a),
    .txready(txready_a), .ftdi_tx(ftdi_tx_a), .busy(busy_a), .fifo_count(fifo_count_a)
  );
  uart_tx_buffered #(.CLK_HZ(16), .BAUD(1), .DEPTH(4)) dut_b (
    .clk_100mhz(clk_100mhz), .rst(rst), .txbyte(txbyte_b), .txvalid(txvalid_b),
    .txready(txready_b), .ftdi_tx(ftdi_tx_b), .busy(busy_b), .fifo_count(fifo_count_b)
  );
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_100mhz);
      #1;
    end
  endtask
  // entered on the first start-bit cycle, returns on the cycle after the stop bit
  task automatic capture_frame(input bit b, input logic [7:0] exp, input string name);
    logic [7:0] got;
    logic exp_bit, line;
    int bad, k;
    got = '0;
    bad = 0;
    for (int t = 0; t < 10 * CPB; t++) begin
      k = t / CPB;
      exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : exp[k-1];
      line = b ? ftdi_tx_b : ftdi_tx_a;
      if (line !== exp_bit) bad++;
      if (t % CPB == CPB / 2 && k >= 1 && k <= 8) got[k-1] = line;
      tick();
    end
    checks++;
    if (got !== exp) begin failures++; $display("FAIL %s_decode: got %h want %h", name, got, exp); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL %s_wave: bad cycles %0d want 0", name, bad); end
  endtask
  task automatic test_reset();
    int bad;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    #1;
    checks++; if (ftdi_tx_a !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", ftdi_tx_a); end
    checks++; if (txready_a !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", txready_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (fifo_count_a !== 5'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", fifo_count_a); end
    checks++; if (txready_b !== 1'b1) begin failures++; $display("FAIL reset_ready_b: got %b want 1", txready_b); end
    checks++; if (ftdi_tx_b !== 1'b1) begin failures++; $display("FAIL reset_tx_b: got %b want 1", ftdi_tx_b); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ftdi_tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL reset_idle_line: bad cycles %0d want 0", bad); end
  endtask
  task automatic test_single_byte();
    txbyte_a = 8'h30;
    txvalid_a = 1'b1;
    tick();
    txvalid_a = 1'b0;
    checks++; if (fifo_count_a !== 5'd1) begin failures++; $display("FAIL single_push_count: got %0d want 1", fifo_count_a); end
    checks++; if (ftdi_tx_a !== 1'b1) begin failures++; $display("FAIL single_push_tx: got %b want 1", ftdi_tx_a); end
    tick();
    checks++; if (fifo_count_a !== 5'd0) begin failures++; $display("FAIL single_pop_count: got %0d want 0", fifo_count_a); end
    checks++; if (ftdi_tx_a !== 1'b0) begin failures++; $display("FAIL single_start: got %b want 0", ftdi_tx_a); end
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy_a); end
    capture_frame(1'b0, 8'h30, "single");
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL single_busy_end: got %b want 0", busy_a); end
    checks++; if (ftdi_tx_a !== 1'b1) begin failures++; $display("FAIL single_idle_end: got %b want 1", ftdi_tx_a); end
  endtask
  task automatic test_back_to_back();
    int rdy_bad;
    rdy_bad = 0;
    fork
      begin
        txvalid_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
          txbyte_a = 8'(32'h30 + i);
          if (txready_a !== 1'b1) rdy_bad++;
          tick();
        end
        txvalid_a = 1'b0;
        checks++; if (rdy_bad != 0) begin failures++; $display("FAIL b2b_ready: low cycles %0d want 0", rdy_bad); end
        checks++; if (fifo_count_a !== 5'd9) begin failures++; $display("FAIL b2b_count: got %0d want 9", fifo_count_a); end
      end
      begin
        tick(2);
        checks++; if (ftdi_tx_a !== 1'b0) begin failures++; $display("FAIL b2b_start: got %b want 0", ftdi_tx_a); end
        for (int f = 0; f < 10; f++) capture_frame(1'b0, 8'(32'h30 + f), "b2b");
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL b2b_busy_end: got %b want 0", busy_a); end
      end
    join
  endtask
  task automatic test_full_fifo();
    int acc [6];
    int exp_acc [6];
    int e, bad;
    logic r;
    exp_acc = '{0, 1, 2, 3, 4, 162};
    e = 0;
    fork
      begin
        txvalid_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
          txbyte_b = 8'(32'h41 + i);
          acc[i] = -1;
          for (int w = 0; w < 400; w++) begin
            r = txready_b;
            tick();
            e++;
            if (r) begin
              acc[i] = e - 1;
              break;
            end
          end
          if (i == 4) begin
            checks++; if (txready_b !== 1'b0) begin failures++; $display("FAIL full_ready: got %b want 0", txready_b); end
            checks++; if (fifo_count_b !== 3'd4) begin failures++; $display("FAIL full_count: got %0d want 4", fifo_count_b); end
          end
        end
        txvalid_b = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) if (acc[i] != exp_acc[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL full_accept_edges: last accepted at edge %0d want 162, %0d wrong", acc[5], bad); end
        checks++; if (fifo_count_b !== 3'd4) begin failures++; $display("FAIL full_refill_count: got %0d want 4", fifo_count_b); end
      end
      begin
        tick(2);
        checks++; if (ftdi_tx_b !== 1'b0) begin failures++; $display("FAIL full_start: got %b want 0", ftdi_tx_b); end
        for (int f = 0; f < 6; f++) capture_frame(1'b1, 8'(32'h41 + f), "full");
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL full_busy_end: got %b want 0", busy_b); end
      end
    join
  endtask
  task automatic test_simultaneous();
    fork
      begin
        txvalid_b = 1'b1;
        txbyte_b = 8'h61;
        tick();
        txbyte_b = 8'h62;
        tick();
        txvalid_b = 1'b0;
        tick(159);
        checks++; if (fifo_count_b !== 3'd1) begin failures++; $display("FAIL simul_pre_count: got %0d want 1", fifo_count_b); end
        txbyte_b = 8'h63;
        txvalid_b = 1'b1;
        tick();
        txvalid_b = 1'b0;
        checks++; if (fifo_count_b !== 3'd1) begin failures++; $display("FAIL simul_count: got %0d want 1", fifo_count_b); end
        checks++; if (ftdi_tx_b !== 1'b0) begin failures++; $display("FAIL simul_start: got %b want 0", ftdi_tx_b); end
      end
      begin
        tick(2);
        for (int f = 0; f < 3; f++) capture_frame(1'b1, 8'(32'h61 + f), "simul");
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL simul_busy_end: got %b want 0", busy_b); end
      end
    join
  endtask
  task automatic test_reset_mid_frame();
    int bad;
    txvalid_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      txbyte_a = 8'(32'h30 + i);
      tick();
    end
    txvalid_a = 1'b0;
    tick(69);
    checks++; if (ftdi_tx_a !== 1'b0) begin failures++; $display("FAIL mid_bit3: got %b want 0", ftdi_tx_a); end
    checks++; if (fifo_count_a !== 5'd2) begin failures++; $display("FAIL mid_count: got %0d want 2", fifo_count_a); end
    rst = 1'b1;
    #1;
    checks++; if (ftdi_tx_a !== 1'b1) begin failures++; $display("FAIL mid_rst_tx: got %b want 1", ftdi_tx_a); end
    checks++; if (fifo_count_a !== 5'd0) begin failures++; $display("FAIL mid_rst_count: got %0d want 0", fifo_count_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL mid_rst_busy: got %b want 0", busy_a); end
    tick(3);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ftdi_tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL mid_idle_after: bad cycles %0d want 0", bad); end
    txbyte_a = 8'h55;
    txvalid_a = 1'b1;
    tick();
    txvalid_a = 1'b0;
    tick();
    checks++; if (ftdi_tx_a !== 1'b0) begin failures++; $display("FAIL mid_new_start: got %b want 0", ftdi_tx_a); end
    capture_frame(1'b0, 8'h55, "mid_new");
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL mid_busy_end: got %b want 0", busy_a); end
  endtask
  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_fifo();
    test_simultaneous();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
